// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the uart_trx transceiver.
package uart_pkg;

    localparam int unsigned FRAME_DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_trx_bitcnt.sv
// Bit-period counter: counts while run_i, wraps after BitCyc clocks, flags mid and last clock.
module uart_trx_bitcnt #(
    parameter int unsigned BitCyc = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic run_i,
    output logic half_o,
    output logic full_o
);

    localparam int unsigned CntW = $clog2(BitCyc) + 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(BitCyc / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(BitCyc - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign half_o = run_i && (cnt_q == HalfLast);
    assign full_o = run_i && (cnt_q == FullLast);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART transceiver, one byte in flight per direction.
// Define UART_TRX_FRAME_ERR_EN to add the frame_err_o stop-bit error pulse.
module uart_trx
    import uart_pkg::*;
#(
    parameter int unsigned ClkFreq   = 50_000_000,
    parameter int unsigned BaudRatio = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tdata_i,
    input  logic       tvld_i,
    output logic       trdy_o,
    output logic       txd_o,
    input  logic       rxd_i,
    output logic       rvld_o,
    output logic [7:0] rdata_o
`ifdef UART_TRX_FRAME_ERR_EN
    ,
    output logic       frame_err_o
`endif
);

    localparam int unsigned BitCyc = ClkFreq / BaudRatio;
    localparam logic [2:0] LastBit = 3'(FRAME_DATA_BITS - 1);

    // ---------------- transmit ----------------
    uart_state_e tx_state_q, tx_state_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        txd_q, txd_d;
    logic        tx_load, tx_full, tx_half_unused;

    uart_trx_bitcnt #(
        .BitCyc(BitCyc)
    ) u_tx_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(tx_load),
        .run_i (tx_state_q != StIdle),
        .half_o(tx_half_unused),
        .full_o(tx_full)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            StIdle: begin
                if (tvld_i) begin
                    tx_state_d = StStart;
                    tx_shift_d = tdata_i;
                    tx_idx_d   = '0;
                    tx_load    = 1'b1;
                end
            end
            StStart: if (tx_full) tx_state_d = StData;
            StData: begin
                if (tx_full) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = tx_idx_q + 3'd1;
                    if (tx_idx_q == LastBit) tx_state_d = StStop;
                end
            end
            StStop: if (tx_full) tx_state_d = StIdle;
            default: tx_state_d = StIdle;
        endcase
        // Line level is registered from the next state so the pin never glitches.
        unique case (tx_state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= StIdle;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            txd_q      <= txd_d;
        end
    end

    assign trdy_o = (tx_state_q == StIdle);
    assign txd_o  = txd_q;

    // ---------------- receive ----------------
    uart_state_e rx_state_q, rx_state_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvld_q, rvld_d;
    logic        rx_load, rx_half, rx_full, rx_line, rx_fall;
`ifdef UART_TRX_FRAME_ERR_EN
    logic        ferr_q, ferr_d;
`endif

    assign rx_line = rx_sync_q[1];
    assign rx_fall = rx_prev_q && !rx_line;

    uart_trx_bitcnt #(
        .BitCyc(BitCyc)
    ) u_rx_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(rx_load),
        .run_i (rx_state_q != StIdle),
        .half_o(rx_half),
        .full_o(rx_full)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        rdata_d    = rdata_q;
        rvld_d     = 1'b0;
        rx_load    = 1'b0;
`ifdef UART_TRX_FRAME_ERR_EN
        ferr_d     = 1'b0;
`endif
        unique case (rx_state_q)
            StIdle: begin
                if (rx_fall) begin
                    rx_state_d = StStart;
                    rx_load    = 1'b1;
                end
            end
            StStart: begin
                if (rx_half) begin
                    rx_state_d = rx_line ? StIdle : StData;
                    rx_idx_d   = '0;
                    rx_load    = 1'b1;
                end
            end
            StData: begin
                if (rx_full) begin
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == LastBit) rx_state_d = StStop;
                end
            end
            StStop: begin
                // A low stop bit returns to idle anyway: idle only starts on a 1->0
                // edge, so it implicitly waits for the line to go high first.
                if (rx_full) begin
                    rx_state_d = StIdle;
                    if (rx_line) begin
                        rdata_d = rx_shift_q;
                        rvld_d  = 1'b1;
                    end else begin
`ifdef UART_TRX_FRAME_ERR_EN
                        ferr_d = 1'b1;
`endif
                    end
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            rdata_q    <= '0;
            rvld_q     <= 1'b0;
`ifdef UART_TRX_FRAME_ERR_EN
            ferr_q     <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rxd_i};
            rx_prev_q  <= rx_line;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
            rdata_q    <= rdata_d;
            rvld_q     <= rvld_d;
`ifdef UART_TRX_FRAME_ERR_EN
            ferr_q     <= ferr_d;
`endif
        end
    end

    assign rvld_o  = rvld_q;
    assign rdata_o = rdata_q;
`ifdef UART_TRX_FRAME_ERR_EN
    assign frame_err_o = ferr_q;
`endif

endmodule

// File: tb/tb_uart_trx.sv
// Scoreboard bench for uart_trx: TX frame capture, loopback, RX glitch/framing, mid-frame reset.
module tb_uart_trx;

    localparam int BC = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tdata = 8'h00;
    logic       tvld = 1'b0;
    logic       trdy, txd, rvld;
    logic [7:0] rdata;
    logic       rxd_drv = 1'b1;
    logic       lb = 1'b0;
    logic       rxd;
    logic       frame_err;

    assign rxd = lb ? txd : rxd_drv;

    int checks = 0;
    int errors = 0;
    int rvld_cnt = 0;
    int fe_cnt = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    logic [9:0] cap_bits;
    bit         cap_stable, cap_busy;
    logic       cap_trdy_end;

    uart_trx dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tdata_i(tdata),
        .tvld_i (tvld),
        .trdy_o (trdy),
        .txd_o  (txd),
        .rxd_i  (rxd),
        .rvld_o (rvld),
        .rdata_o(rdata)
`ifdef UART_TRX_FRAME_ERR_EN
        ,
        .frame_err_o(frame_err)
`endif
    );

`ifndef UART_TRX_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // RX scoreboard: every rvld pulse pops one expected byte.
    always @(negedge clk) begin
        if (rvld === 1'b1) begin
            rvld_cnt++;
            checks++;
            if (rx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: rvld with rdata=%02h, none expected", rdata);
            end else begin
                logic [7:0] exp;
                exp = rx_exp_q.pop_front();
                if (rdata !== exp) begin
                    errors++;
                    $display("FAIL rx_data: got %02h expected %02h", rdata, exp);
                end
            end
        end
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for trdy, then presents a byte for one accepted cycle.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (trdy !== 1'b1 && n < 20 * BC) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trdy !== 1'b1) begin
            errors++;
            $display("FAIL send_wait: trdy=%b expected 1 within budget", trdy);
        end
        tdata = b;
        tvld  = 1'b1;
        @(posedge clk);
        #1;
        tvld  = 1'b0;
        tdata = 8'($urandom);
    endtask

    // Records one TX frame starting in the cycle after acceptance.
    task automatic capture_tx(output logic [9:0] bits, output bit stable, output bit busy,
                              output logic trdy_end);
        logic first = 1'b0;
        bits   = '0;
        stable = 1'b1;
        busy   = 1'b1;
        for (int c = 0; c < 10 * BC; c++) begin
            @(negedge clk);
            if (c % BC == 0) first = txd;
            else if (txd !== first) stable = 1'b0;
            if (c % BC == BC / 2) bits[c / BC] = txd;
            if (trdy !== 1'b0) busy = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        trdy_end = trdy;
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        repeat (BC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (BC) @(posedge clk);
        end
        rxd_drv = stop;
        repeat (BC) @(posedge clk);
        rxd_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 4;
        if (trdy !== 1'b1) begin errors++; $display("FAIL reset_trdy: got %b expected 1", trdy); end
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        if (rvld !== 1'b0) begin errors++; $display("FAIL reset_rvld: got %b expected 0", rvld); end
        if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", rdata); end
    endtask

    task automatic check_tx_frame(input string name);
        logic [7:0] exp;
        logic [9:0] frame;
        exp   = tx_exp_q.pop_front();
        frame = {1'b1, exp, 1'b0};
        checks += 4;
        if (cap_bits !== frame) begin
            errors++;
            $display("FAIL %s_bits: got %b expected %b (lsb=start)", name, cap_bits, frame);
        end
        if (!cap_stable) begin errors++; $display("FAIL %s_bitlen: got unstable bit expected %0d-cycle bits", name, BC); end
        if (!cap_busy) begin errors++; $display("FAIL %s_busy: got trdy=1 mid-frame expected 0", name); end
        if (cap_trdy_end !== 1'b1) begin
            errors++;
            $display("FAIL %s_trdy_end: got %b expected 1 after %0d cycles", name, cap_trdy_end, 10 * BC);
        end
    endtask

    task automatic test_tx_single();
        tx_exp_q.push_back(8'h68);
        send_byte(8'h68);
        capture_tx(cap_bits, cap_stable, cap_busy, cap_trdy_end);
        check_tx_frame("tx_single");
    endtask

    task automatic test_ignore_busy();
        bit idle_ok = 1'b1;
        tx_exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        fork
            capture_tx(cap_bits, cap_stable, cap_busy, cap_trdy_end);
            begin
                repeat (2 * BC) @(posedge clk);
                #1 tdata = 8'hFF;
                tvld = 1'b1;
                repeat (BC) @(posedge clk);
                #1 tvld = 1'b0;
            end
        join
        check_tx_frame("tx_ignore");
        for (int c = 0; c < 2 * BC; c++) begin
            @(negedge clk);
            if (txd !== 1'b1 || trdy !== 1'b1) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin errors++; $display("FAIL tx_ignore_queued: got line activity expected idle"); end
    endtask

    task automatic test_loopback();
        logic [7:0] msg [5];
        int base, n;
        msg = '{8'h68, 8'h65, 8'h6C, 8'h70, 8'h0A};
        base = rvld_cnt;
        lb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_exp_q.push_back(msg[i]);
            send_byte(msg[i]);
        end
        n = 0;
        while (rx_exp_q.size() != 0 && n < 20 * BC) begin
            @(negedge clk);
            n++;
        end
        lb = 1'b0;
        checks += 3;
        if (rx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL loop_pending: got %0d bytes outstanding expected 0", rx_exp_q.size());
        end
        if (rvld_cnt - base != 5) begin errors++; $display("FAIL loop_count: got %0d expected 5", rvld_cnt - base); end
        if (rdata !== 8'h0A) begin errors++; $display("FAIL loop_hold: got %02h expected 0a", rdata); end
        repeat (2 * BC) @(posedge clk);
    endtask

    task automatic test_rx_errors();
        int base, fe_base;
        base = rvld_cnt;
        @(posedge clk);
        #1 rxd_drv = 1'b0;
        repeat (100) @(posedge clk);
        rxd_drv = 1'b1;
        repeat (2 * BC) @(posedge clk);
        checks++;
        if (rvld_cnt != base) begin errors++; $display("FAIL rx_glitch: got %0d pulses expected 0", rvld_cnt - base); end

        fe_base = fe_cnt;
        drive_rx_frame(8'h55, 1'b0);
        repeat (2 * BC) @(posedge clk);
        checks++;
        if (rvld_cnt != base) begin errors++; $display("FAIL rx_framing: got %0d pulses expected 0", rvld_cnt - base); end
`ifdef UART_TRX_FRAME_ERR_EN
        checks++;
        if (fe_cnt - fe_base != 1) begin
            errors++;
            $display("FAIL rx_frame_err: got %0d pulses expected 1", fe_cnt - fe_base);
        end
`endif

        rx_exp_q.push_back(8'hA5);
        drive_rx_frame(8'hA5, 1'b1);
        repeat (BC) @(posedge clk);
        checks += 3;
        if (rx_exp_q.size() != 0) begin errors++; $display("FAIL rx_after_err: got no rvld expected a5"); end
        if (rvld_cnt - base != 1) begin errors++; $display("FAIL rx_after_cnt: got %0d expected 1", rvld_cnt - base); end
        if (rdata !== 8'hA5) begin errors++; $display("FAIL rx_after_data: got %02h expected a5", rdata); end
    endtask

    task automatic test_reset_mid_tx();
        send_byte(8'hC3);
        repeat (4 * BC + BC / 2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL rst_mid_bit3: got %b expected 0", txd); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks += 2;
        if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
        if (trdy !== 1'b1) begin errors++; $display("FAIL rst_mid_trdy: got %b expected 1", trdy); end
        tx_exp_q.push_back(8'h0F);
        send_byte(8'h0F);
        capture_tx(cap_bits, cap_stable, cap_busy, cap_trdy_end);
        check_tx_frame("tx_after_rst");
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_ignore_busy();
        test_loopback();
        test_rx_errors();
        test_reset_mid_tx();
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_trx.md
Name: uart_trx

Overview:
- Full-duplex 8N1 UART transceiver: one transmit channel (byte handshake to serial line) and one receive channel (serial line to byte strobe), sharing one clock.
- Sits between the SoC bus-side UART registers, or bench byte sources and sinks, and the board pins.
- No FIFOs; one byte in flight per direction.

Parameters:
- clk_freq, 50_000_000: system clock frequency in Hz.
- baud_ratio, 115200: line baud rate.
- Derived: BIT_CYC = clk_freq/baud_ratio, integer-truncated; 434 at defaults.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tdata  in  8  byte to transmit.
- tvld  in  1  tdata valid.
- trdy  out  1  transmitter idle; a byte is accepted when tvld&&trdy.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous.
- rvld  out  1  one-cycle pulse; rdata holds a received byte.
- rdata  out  8  last received byte; held until the next byte.

Behaviour:
- Reset values: trdy=1, txd=1, rvld=0, rdata=8'h00, both FSMs IDLE, counters 0. Reset mid-frame aborts immediately; txd returns high the next cycle.
- Frame format: start bit 0, data bits d0..d7 (LSB first), stop bit 1. Each bit lasts exactly BIT_CYC clocks.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - In IDLE, trdy=1. On a clk edge with tvld&&trdy, tdata is latched, trdy=0 and txd=0 from the next cycle.
  - trdy returns to 1 in the cycle after the last stop-bit clock. Frame length = 10*BIT_CYC cycles; the next byte's start bit may begin in the cycle after that.
  - tvld while trdy=0 is ignored; the byte is not queued. tdata changes after acceptance have no effect.
- RX path:
  - rxd is passed through a 2-flop synchronizer, with its reset value 1.
  - RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: a 1->0 transition on the synchronized line starts a frame.
  - START: waits BIT_CYC/2 cycles, then resamples. If the line is 1, the event is a glitch: return to IDLE with no output.
  - DATA: samples at each subsequent BIT_CYC interval (mid-bit), shifting LSB first.
  - STOP: samples the stop bit at mid-bit.
    - Stop=1: rdata is updated and rvld=1 for exactly one cycle. Both happen in the same cycle.
    - Stop=0 (framing error): the byte is discarded, rdata and rvld stay unchanged, and the FSM waits for the line to go high before re-entering IDLE.
  - The FSM re-arms at mid-stop, so back-to-back frames with no idle gap are received.
- TX and RX are fully independent. Simultaneous activity and loopback (txd wired to rxd) must work.
- Arithmetic: counters are sized $clog2(BIT_CYC)+1 bits, and bit index is 3 bits, so no wrap-around issue at the defaults.

Optional Feature:
- Macro: UART_TRX_FRAME_ERR_EN.
- Defined: adds output port frame_err (1 bit), reset 0. It pulses high for one cycle at the mid-stop sample when the stop bit reads 0. rvld stays 0 for that frame.
- Undefined: no port; framing errors are silently dropped as described above.

Decomposition:
- Package uart_pkg: constants FRAME_DATA_BITS=8 and the TX/RX state enum typedef (IDLE, START, DATA, STOP).
- BIT_CYC is derived locally from the parameters.
- One natural sub-module, uart_trx_bitcnt: a reusable baud/bit-period counter (load, run, half-period and full-period tick), instantiated once for TX and once for RX.
- TX and RX FSMs stay in uart_trx.

Test Plan:
- Reset: rst=1 for 3 cycles -> trdy=1, txd=1, rvld=0, rdata=8'h00.
- TX single byte: tvld=1, tdata=8'h68 ('h') for one cycle with trdy=1.
  - trdy falls next cycle.
  - txd shows 0,0,0,0,1,0,1,1,0,1, each bit 434 cycles long.
  - trdy rises after 4340 cycles.
- Loopback txd->rxd, sending "help\n" (8'h68,8'h65,8'h6C,8'h70,8'h0A), each on the trdy rising edge -> five rvld pulses with rdata matching, in order.
- tvld asserted while trdy=0 with 8'hFF -> ignored; only the original byte appears on txd.
- RX glitch and framing error:
  - rxd low for 100 cycles -> no rvld.
  - A frame with 8'h55 and stop=0 -> no rvld; frame_err pulses if UART_TRX_FRAME_ERR_EN is defined.
  - A following valid 8'hA5 frame -> rvld with rdata=8'hA5.
- Reset mid-TX: assert rst during DATA bit 3 -> txd=1 and trdy=1 the next cycle; a new byte 8'h0F then transmits correctly.
